// File: rtl/dma_prog_sequencer.sv
// -----------------------------------------------------------------------------
// dma_prog_sequencer
//
// Purpose: turns DMA move instructions from the core into an ordered series of
// DMA-controller register writes. The source operand (op 57) is remembered per
// channel. The destination operand (op 59) then emits the full programming
// sequence: DEST/BASE, MODE, CMD, MASK and REQ.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_cmd_valid    in   instruction present
//   o_cmd_ready    out  sequencer idle, instruction accepted when valid
//   i_op_code      in   [5:0] opcode (56 count, 57 source, 59 dest/start)
//   i_cmd_ch       in   [CW-1:0] target channel
//   i_move_data    in   [DW-1:0] operand
//   o_reg_wr       out  register write request
//   o_reg_addr     out  [AW-1:0] target register
//   o_reg_data     out  [DW-1:0] write data
//   i_reg_ack      in   controller accepted the current write
//   o_done         out  one-cycle pulse at sequence completion
//   o_err          out  one-cycle pulse on illegal instruction / abort
//
// Optional feature: define DMA_SEQ_TIMEOUT_EN to add an acknowledge watchdog.
// The write is abandoned after TIMEOUT_CYC WRITE cycles without reg_ack.
// -----------------------------------------------------------------------------
module dma_prog_sequencer #(
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned NCH         = 4,
    parameter int unsigned IO_BOUND    = 32764,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned CW         = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [5:0]    i_op_code,
    input  logic [CW-1:0] i_cmd_ch,
    input  logic [DW-1:0] i_move_data,
    output logic          o_reg_wr,
    output logic [AW-1:0] o_reg_addr,
    output logic [DW-1:0] o_reg_data,
    input  logic          i_reg_ack,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [5:0] OP_COUNT = 6'd56;
    localparam logic [5:0] OP_SRC   = 6'd57;
    localparam logic [5:0] OP_DST   = 6'd59;

    localparam logic [AW-1:0] A_CMD  = AW'(8);
    localparam logic [AW-1:0] A_REQ  = AW'(9);
    localparam logic [AW-1:0] A_MASK = AW'(10);
    localparam logic [AW-1:0] A_MODE = AW'(11);
    localparam logic [AW-1:0] A_DEST = AW'(12);

    typedef enum logic [1:0] {StIdle, StWrite, StDone, StErr} state_e;

    state_e          r_state;
    logic [NCH-1:0]  r_src_valid;
    logic [NCH-1:0]  r_src_io;
    logic [AW-1:0]   r_step_addr [5];
    logic [DW-1:0]   r_step_data [5];
    logic [2:0]      r_idx;
    logic [2:0]      r_last;

    logic [AW-1:0]   w_step_addr [5];
    logic [DW-1:0]   w_step_data [5];
    logic [2:0]      w_last;
    logic            w_illegal;
    logic            w_no_write;
    logic            w_op_mem;
    logic            w_src_valid;
    logic            w_src_io;
    logic [DW-1:0]   w_ch_dw;
    logic [2:0]      w_next_idx;
    logic            w_accept;

`ifdef DMA_SEQ_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC >= 256) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TW-1:0]   r_tmo_cnt;
    logic [CW-1:0]   r_ch;
`endif

    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_op_mem    = (i_move_data <= DW'(IO_BOUND));
    assign w_src_valid = r_src_valid[i_cmd_ch];
    assign w_src_io    = r_src_io[i_cmd_ch];
    assign w_ch_dw     = DW'(i_cmd_ch);
    assign w_next_idx  = r_idx + 3'd1;

    // Build the step list for the instruction on the inputs. It is captured
    // only when the instruction is accepted.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_step_addr[i] = '0;
            w_step_data[i] = '0;
        end
        w_last     = 3'd0;
        w_illegal  = 1'b0;
        w_no_write = 1'b0;
        unique case (i_op_code)
            OP_COUNT: begin
                w_step_addr[0] = AW'({i_cmd_ch, 1'b1});
                w_step_data[0] = i_move_data;
            end
            OP_SRC: begin
                if (w_op_mem) begin
                    w_step_addr[0] = AW'({i_cmd_ch, 1'b0});
                    w_step_data[0] = i_move_data;
                end else begin
                    // IO source: only remembered, the BASE write is deferred to op 59
                    w_no_write = 1'b1;
                end
            end
            OP_DST: begin
                if (!w_src_valid || (w_src_io && !w_op_mem)) begin
                    w_illegal = 1'b1;
                end else if (!w_src_io && w_op_mem) begin
                    // mem -> mem
                    w_step_addr[0] = A_DEST;  w_step_data[0] = i_move_data;
                    w_step_addr[1] = A_MODE;  w_step_data[1] = w_ch_dw;
                    w_step_addr[2] = A_CMD;   w_step_data[2] = DW'(1);
                    w_step_addr[3] = A_MASK;  w_step_data[3] = w_ch_dw;
                    w_step_addr[4] = A_REQ;   w_step_data[4] = w_ch_dw | DW'(4);
                    w_last         = 3'd4;
                end else if (!w_src_io) begin
                    // mem -> IO: the IO port number is implied, nothing to load
                    w_step_addr[0] = A_MODE;  w_step_data[0] = w_ch_dw | DW'(8);
                    w_step_addr[1] = A_CMD;   w_step_data[1] = '0;
                    w_step_addr[2] = A_MASK;  w_step_data[2] = w_ch_dw;
                    w_step_addr[3] = A_REQ;   w_step_data[3] = w_ch_dw | DW'(4);
                    w_last         = 3'd3;
                end else begin
                    // IO -> mem: the memory side goes into the channel BASE
                    w_step_addr[0] = AW'({i_cmd_ch, 1'b0});
                    w_step_data[0] = i_move_data;
                    w_step_addr[1] = A_MODE;  w_step_data[1] = w_ch_dw | DW'(4);
                    w_step_addr[2] = A_CMD;   w_step_data[2] = '0;
                    w_step_addr[3] = A_MASK;  w_step_data[3] = w_ch_dw;
                    w_step_addr[4] = A_REQ;   w_step_data[4] = w_ch_dw | DW'(4);
                    w_last         = 3'd4;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            o_cmd_ready <= 1'b1;
            o_reg_wr    <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_data  <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            r_src_valid <= '0;
            r_src_io    <= '0;
            r_step_addr <= '{default: '0};
            r_step_data <= '{default: '0};
            r_idx       <= '0;
            r_last      <= '0;
`ifdef DMA_SEQ_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_ch        <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        o_cmd_ready <= 1'b0;
                        r_step_addr <= w_step_addr;
                        r_step_data <= w_step_data;
                        r_last      <= w_last;
                        r_idx       <= '0;
`ifdef DMA_SEQ_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
                        r_ch        <= i_cmd_ch;
`endif
                        if (i_op_code == OP_SRC) begin
                            r_src_valid[i_cmd_ch] <= 1'b1;
                            r_src_io[i_cmd_ch]    <= ~w_op_mem;
                        end else if (i_op_code == OP_DST) begin
                            r_src_valid[i_cmd_ch] <= 1'b0;
                        end
                        if (w_illegal) begin
                            r_state <= StErr;
                            o_err   <= 1'b1;
                        end else if (w_no_write) begin
                            r_state <= StDone;
                            o_done  <= 1'b1;
                        end else begin
                            r_state    <= StWrite;
                            o_reg_wr   <= 1'b1;
                            o_reg_addr <= w_step_addr[0];
                            o_reg_data <= w_step_data[0];
                        end
                    end
                end
                StWrite: begin
                    if (i_reg_ack) begin
`ifdef DMA_SEQ_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (r_idx != r_last) begin
                            r_idx      <= w_next_idx;
                            o_reg_addr <= r_step_addr[w_next_idx];
                            o_reg_data <= r_step_data[w_next_idx];
                        end else begin
                            o_reg_wr <= 1'b0;
                            o_done   <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
`ifdef DMA_SEQ_TIMEOUT_EN
                    else if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        // Controller never answered: drop the sequence entirely
                        o_reg_wr          <= 1'b0;
                        o_err             <= 1'b1;
                        r_src_valid[r_ch] <= 1'b0;
                        o_cmd_ready       <= 1'b1;
                        r_state           <= StIdle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                StDone: begin
                    o_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                StErr: begin
                    o_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                default: begin
                    o_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_prog_sequencer.sv
module tb_dma_prog_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [5:0]  i_op_code = '0;
    logic [1:0]  i_cmd_ch = '0;
    logic [15:0] i_move_data = '0;
    logic        o_reg_wr;
    logic [3:0]  o_reg_addr;
    logic [15:0] o_reg_data;
    logic        i_reg_ack = 1'b0;
    logic        o_done;
    logic        o_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dma_prog_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_op_code   (i_op_code),
        .i_cmd_ch    (i_cmd_ch),
        .i_move_data (i_move_data),
        .o_reg_wr    (o_reg_wr),
        .o_reg_addr  (o_reg_addr),
        .o_reg_data  (o_reg_data),
        .i_reg_ack   (i_reg_ack),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, presents one instruction for one cycle.
    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [1:0] ch, input logic [15:0] d);
        int n = 0;
        while (o_cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait_ready: cmd_ready=%b, want 1", o_cmd_ready);
        end
        i_op_code   = op;
        i_cmd_ch    = ch;
        i_move_data = d;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (o_cmd_ready !== 1'b1 || o_reg_wr !== 1'b0 || o_reg_addr !== 4'd0 ||
            o_reg_data !== 16'd0 || o_done !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b wr=%b addr=%0d data=%h done=%b err=%b, want 1 0 0 0000 0 0",
                     o_cmd_ready, o_reg_wr, o_reg_addr, o_reg_data, o_done, o_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_cmd_ready !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b wr=%b, want 1 0", o_cmd_ready, o_reg_wr);
        end
    endtask

    task automatic test_count();
        i_reg_ack = 1'b1;
        send(6'd56, 2'd2, 16'h0040);
        checks++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== 4'd5 || o_reg_data !== 16'h0040 ||
            o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL count_write: wr=%b addr=%0d data=%h rdy=%b, want 1 5 0040 0",
                     o_reg_wr, o_reg_addr, o_reg_data, o_cmd_ready);
        end
        tick();
        checks++;
        if (o_done !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL count_done: done=%b wr=%b, want 1 0", o_done, o_reg_wr);
        end
        tick();
        checks++;
        if (o_cmd_ready !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL count_ready: rdy=%b done=%b, want 1 0", o_cmd_ready, o_done);
        end
        // ack held high while idle must not start anything
        tick();
        checks++;
        if (o_reg_wr !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: wr=%b done=%b err=%b, want 0 0 0",
                     o_reg_wr, o_done, o_err);
        end
    endtask

    task automatic test_mem_mem();
        logic [3:0]  ea [5] = '{4'd12, 4'd11, 4'd8, 4'd10, 4'd9};
        logic [15:0] ed [5] = '{16'h2000, 16'h0000, 16'h0001, 16'h0000, 16'h0004};
        i_reg_ack = 1'b1;
        send(6'd57, 2'd0, 16'h1000);
        checks++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== 4'd0 || o_reg_data !== 16'h1000) begin
            errors++;
            $display("FAIL mm_base0: wr=%b addr=%0d data=%h, want 1 0 1000",
                     o_reg_wr, o_reg_addr, o_reg_data);
        end
        send(6'd59, 2'd0, 16'h2000);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_reg_wr !== 1'b1 || o_reg_addr !== ea[i] || o_reg_data !== ed[i]) begin
                errors++;
                $display("FAIL mm_step%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, o_reg_wr, o_reg_addr, o_reg_data, ea[i], ed[i]);
            end
            tick();
        end
        checks++;
        if (o_done !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL mm_done: done=%b wr=%b, want 1 0", o_done, o_reg_wr);
        end
    endtask

    task automatic test_io_src();
        logic [3:0]  ea [5] = '{4'd2, 4'd11, 4'd8, 4'd10, 4'd9};
        logic [15:0] ed [5] = '{16'h0100, 16'h0005, 16'h0000, 16'h0001, 16'h0005};
        i_reg_ack = 1'b1;
        send(6'd57, 2'd1, 16'h9000);
        checks++;
        if (o_reg_wr !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL io_src_nowrite: wr=%b done=%b, want 0 1", o_reg_wr, o_done);
        end
        send(6'd59, 2'd1, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_reg_wr !== 1'b1 || o_reg_addr !== ea[i] || o_reg_data !== ed[i]) begin
                errors++;
                $display("FAIL iom_step%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, o_reg_wr, o_reg_addr, o_reg_data, ea[i], ed[i]);
            end
            tick();
        end
        checks++;
        if (o_done !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL iom_done: done=%b wr=%b, want 1 0", o_done, o_reg_wr);
        end
    endtask

    task automatic test_illegal();
        i_reg_ack = 1'b1;
        send(6'd59, 2'd3, 16'h0000);
        checks++;
        if (o_err !== 1'b1 || o_reg_wr !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL no_src_err: err=%b wr=%b done=%b, want 1 0 0", o_err, o_reg_wr, o_done);
        end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_reg_wr !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b wr=%b rdy=%b, want 0 0 1",
                     o_err, o_reg_wr, o_cmd_ready);
        end
        send(6'd57, 2'd3, 16'h8000);
        checks++;
        if (o_done !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL io_src_ch3: done=%b wr=%b, want 1 0", o_done, o_reg_wr);
        end
        send(6'd59, 2'd3, 16'h8004);
        checks++;
        if (o_err !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL io_io_err: err=%b wr=%b, want 1 0", o_err, o_reg_wr);
        end
        send(6'd60, 2'd0, 16'h0000);
        checks++;
        if (o_err !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode_err: err=%b wr=%b, want 1 0", o_err, o_reg_wr);
        end
    endtask

    task automatic test_boundary();
        logic [3:0]  ea [5] = '{4'd12, 4'd11, 4'd8, 4'd10, 4'd9};
        logic [15:0] ed [5] = '{16'h7FFC, 16'h0002, 16'h0001, 16'h0002, 16'h0006};
        i_reg_ack = 1'b1;
        send(6'd57, 2'd2, 16'h9000);
        // re-issue overwrites the IO source with a memory source at the exact bound
        send(6'd57, 2'd2, 16'h7FFC);
        checks++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== 4'd4 || o_reg_data !== 16'h7FFC) begin
            errors++;
            $display("FAIL bound_is_mem: wr=%b addr=%0d data=%h, want 1 4 7ffc",
                     o_reg_wr, o_reg_addr, o_reg_data);
        end
        send(6'd59, 2'd2, 16'h7FFC);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_reg_wr !== 1'b1 || o_reg_addr !== ea[i] || o_reg_data !== ed[i]) begin
                errors++;
                $display("FAIL bound_step%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, o_reg_wr, o_reg_addr, o_reg_data, ea[i], ed[i]);
            end
            tick();
        end
        send(6'd59, 2'd2, 16'h0010);
        checks++;
        if (o_err !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL src_consumed: err=%b wr=%b, want 1 0", o_err, o_reg_wr);
        end
    endtask

    task automatic test_multi_channel();
        logic [3:0]  ea [5] = '{4'd2, 4'd11, 4'd8, 4'd10, 4'd9};
        logic [15:0] ed [5] = '{16'h0200, 16'h0005, 16'h0000, 16'h0001, 16'h0005};
        logic [3:0]  fa [4] = '{4'd11, 4'd8, 4'd10, 4'd9};
        logic [15:0] fd [4] = '{16'h0008, 16'h0000, 16'h0000, 16'h0004};
        i_reg_ack = 1'b1;
        send(6'd57, 2'd0, 16'h0100);
        send(6'd57, 2'd1, 16'h9000);
        send(6'd59, 2'd1, 16'h0200);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_reg_wr !== 1'b1 || o_reg_addr !== ea[i] || o_reg_data !== ed[i]) begin
                errors++;
                $display("FAIL multi_ch1_step%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, o_reg_wr, o_reg_addr, o_reg_data, ea[i], ed[i]);
            end
            tick();
        end
        send(6'd59, 2'd0, 16'hA000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_reg_wr !== 1'b1 || o_reg_addr !== fa[i] || o_reg_data !== fd[i]) begin
                errors++;
                $display("FAIL multi_ch0_step%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, o_reg_wr, o_reg_addr, o_reg_data, fa[i], fd[i]);
            end
            tick();
        end
        checks++;
        if (o_done !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL multi_done: done=%b wr=%b, want 1 0", o_done, o_reg_wr);
        end
    endtask

    task automatic test_ack_delay_reset();
        logic [3:0]  fa [3] = '{4'd11, 4'd8, 4'd10};
        logic [15:0] fd [3] = '{16'h0008, 16'h0000, 16'h0000};
        i_reg_ack = 1'b1;
        send(6'd57, 2'd0, 16'h0300);
        tick();
        i_reg_ack = 1'b0;
        send(6'd59, 2'd0, 16'hA000);
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (o_reg_wr !== 1'b1 || o_reg_addr !== fa[k] || o_reg_data !== fd[k]) begin
                    errors++;
                    $display("FAIL delay_hold%0d_%0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                             k, w, o_reg_wr, o_reg_addr, o_reg_data, fa[k], fd[k]);
                end
                tick();
            end
            i_reg_ack = 1'b1;
            tick();
            i_reg_ack = 1'b0;
        end
        checks++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== fa[2] || o_reg_data !== fd[2]) begin
            errors++;
            $display("FAIL delay_third: wr=%b addr=%0d data=%h, want 1 %0d %h",
                     o_reg_wr, o_reg_addr, o_reg_data, fa[2], fd[2]);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_reg_wr !== 1'b0 || o_reg_addr !== 4'd0 || o_reg_data !== 16'd0 ||
            o_done !== 1'b0 || o_err !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midseq_reset: wr=%b addr=%0d data=%h done=%b err=%b rdy=%b, want 0 0 0000 0 0 1",
                     o_reg_wr, o_reg_addr, o_reg_data, o_done, o_err, o_cmd_ready);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_reg_wr !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_resume: wr=%b rdy=%b, want 0 1", o_reg_wr, o_cmd_ready);
        end
        i_reg_ack = 1'b1;
        send(6'd59, 2'd0, 16'h0010);
        checks++;
        if (o_err !== 1'b1 || o_reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_src: err=%b wr=%b, want 1 0", o_err, o_reg_wr);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_mem_mem();
        test_io_src();
        test_illegal();
        test_boundary();
        test_multi_channel();
        test_ack_delay_reset();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
